// File: rtl/display_plane_scaler_pkg.sv
// Shared constants for the display plane scaler: default geometry, pixel width
// and the legacy-compatible state encoding.
package display_pkg;

    localparam int unsigned PIXEL_W_DEF     = 24;
    localparam int unsigned IMG_W_DEF       = 80;
    localparam int unsigned IMG_H_DEF       = 60;
    localparam int unsigned SCALE_SHIFT_DEF = 3;
    localparam int unsigned ADDR_W_DEF      = 13;
    localparam int unsigned ROM_LAT_DEF     = 1;

    localparam int unsigned STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/display_plane_scaler_skid_fifo.sv
// Small synchronous FIFO carrying a pixel plus a start-of-frame tag; absorbs
// ROM returns while the downstream FIFO is back-pressuring.
module pixel_skid_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         push_sof_i,
    input  logic                         pop_i,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [WIDTH-1:0]             head_data_o,
    output logic                         head_sof_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH:0]     mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        count_d  = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= {push_sof_i, push_data_i};
                wr_ptr_q        <= wr_ptr_d;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_d;
            end
            count_q <= count_d;
        end
    end

    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_data_o = mem_q[rd_ptr_q][WIDTH-1:0];
    assign head_sof_o  = mem_q[rd_ptr_q][WIDTH];

endmodule

// File: rtl/display_plane_scaler.sv
// Fetches a stored image from ROM, up-scales it by 2^SCALE_SHIFT in both axes
// and streams it in raster order into the VGA output FIFO.
module display_plane_scaler
    import display_pkg::*;
#(
    parameter int unsigned PIXEL_W     = PIXEL_W_DEF,
    parameter int unsigned IMG_W       = IMG_W_DEF,
    parameter int unsigned IMG_H       = IMG_H_DEF,
    parameter int unsigned SCALE_SHIFT = SCALE_SHIFT_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned ROM_LAT     = ROM_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               fifo_full,
    input  logic [PIXEL_W-1:0] in_pixel,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               fifo_wr,
    output logic [PIXEL_W-1:0] out_pixel,
    output logic               out_sof,
    output logic               frame_done
);

    localparam int unsigned H_RES = IMG_W << SCALE_SHIFT;
    localparam int unsigned V_RES = IMG_H << SCALE_SHIFT;
    localparam int unsigned XW    = $clog2(H_RES + 1);
    localparam int unsigned YW    = $clog2(V_RES + 1);
    localparam int unsigned D     = ROM_LAT + 2;
    localparam int unsigned OCC_W = $clog2(D + 1);
    localparam int unsigned IF_W  = $clog2(ROM_LAT + 1);

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
    localparam logic [YW-1:0] Y_MASK = YW'((1 << SCALE_SHIFT) - 1);

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [ROM_LAT-1:0]  vld_q, vsof_q;
    logic                frame_done_q;

    logic [IF_W-1:0]     inflight;
    logic [OCC_W-1:0]    fifo_count;
    logic [OCC_W-1:0]    occ;
    logic                issue;
    logic                last_write;
    logic                skid_empty;
    logic                head_sof;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + IF_W'(vld_q[i]);
        end
    end

    // Occupancy counts reads still in the ROM pipe, so issuing can never
    // overrun the skid buffer regardless of how long fifo_full is held.
    assign occ        = fifo_count + OCC_W'(inflight);
    assign issue      = (state_q == ST_RUN) && (occ < OCC_W'(D));
    assign fifo_wr    = !skid_empty && !fifo_full;
    assign last_write = (state_q == ST_DRAIN) && fifo_wr &&
                        (inflight == '0) && (fifo_count == OCC_W'(1));

    assign rom_en     = issue;
    assign rom_addr   = row_base_q + ADDR_W'(x_q >> SCALE_SHIFT);
    assign out_sof    = head_sof && fifo_wr;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (issue) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d        = '0;
                            row_base_d = '0;
                            state_d    = ST_DRAIN;
                        end else begin
                            y_d = y_q + 1'b1;
                            if (((y_q + 1'b1) & Y_MASK) == '0) begin
                                row_base_d = row_base_q + ADDR_W'(IMG_W);
                            end
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (last_write) state_d = enable ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            row_base_q   <= '0;
            vld_q        <= '0;
            vsof_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            row_base_q   <= row_base_d;
            vld_q[0]     <= issue;
            vsof_q[0]    <= issue && (x_q == '0) && (y_q == '0);
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                vsof_q[i] <= vsof_q[i-1];
            end
            frame_done_q <= last_write;
        end
    end

    pixel_skid_fifo #(
        .DEPTH (D),
        .WIDTH (PIXEL_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (vld_q[ROM_LAT-1]),
        .push_data_i (in_pixel),
        .push_sof_i  (vsof_q[ROM_LAT-1]),
        .pop_i       (fifo_wr),
        .empty_o     (skid_empty),
        .count_o     (fifo_count),
        .head_data_o (out_pixel),
        .head_sof_o  (head_sof)
    );

endmodule
